// File: rtl/ahb_mem_slave_responder_if.sv
// AHB-Lite bus bundle between a master/decoder and one memory-backed responder.
interface ahb_mem_slave_responder_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  hsel;
   logic [ADDR_WIDTH-1:0] haddr;
   logic [1:0]            htrans;
   logic                  hwrite;
   logic [2:0]            hsize;
   logic [2:0]            hburst;
   logic [DATA_WIDTH-1:0] hwdata;
   logic                  hready;
   logic                  hreadyout;
   logic [1:0]            hresp;
   logic [DATA_WIDTH-1:0] hrdata;

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
      input  hreadyout, hresp, hrdata
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
      output hreadyout, hresp, hrdata
   );
endinterface

// File: rtl/ahb_mem_slave_responder.sv
// AHB-Lite responder over a word-addressed memory: programmable wait states,
// two-cycle ERROR on bad size/alignment/range, byte-lane writes, full-word reads.
module ahb_mem_slave_responder #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_WORDS   = 64,
   parameter int WAIT_STATES = 0
) (
   input logic                      hclk,
   input logic                      hreset,
   ahb_mem_slave_responder_if.slave bus
);
   localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   typedef struct packed {
      logic [IDX_W+1:0] addr;
      logic             write;
      logic [1:0]       size;
   } req_t;

   state_t                state_q, state_d;
   req_t                  req_q;
   logic [3:0]            cnt_q;
   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   logic        can_accept, accept, bad_req, oob;
   logic [29:0] off;
   logic [3:0]  be;
   logic        rdy;
   logic        err;
   logic [DATA_WIDTH-1:0] rdata;

   logic unused_bits;
   assign unused_bits = ^{bus.haddr[ADDR_WIDTH-1:30], bus.hburst};

   // Only states that present hreadyout=1 close an address phase.
   assign can_accept = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
   assign accept     = can_accept && bus.hsel && bus.hready && bus.htrans[1];

   assign off     = bus.haddr[29:0];
   assign oob     = (32'(off) >= 32'(MEM_WORDS * 4));
   assign bad_req = (bus.hsize > 3'd2)
                 || ((bus.hsize == 3'd1) && bus.haddr[0])
                 || ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00))
                 || oob;

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q <= S_IDLE;
         req_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            req_q.addr  <= bus.haddr[IDX_W+1:0];
            req_q.write <= bus.hwrite;
            req_q.size  <= bus.hsize[1:0];
            cnt_q       <= 4'(WAIT_STATES);
         end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q - 4'd1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_WAIT: if (cnt_q <= 4'd1) state_d = S_DATA;
         S_ERR1: state_d = S_ERR2;
         default: begin
            if (accept) begin
               if (bad_req)              state_d = S_ERR1;
               else if (WAIT_STATES > 0) state_d = S_WAIT;
               else                      state_d = S_DATA;
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      rdy   = 1'b1;
      err   = 1'b0;
      rdata = '0;
      case (state_q)
         S_WAIT: rdy = 1'b0;
         S_ERR1: begin rdy = 1'b0; err = 1'b1; end
         S_ERR2: err = 1'b1;
         S_DATA: if (!req_q.write) rdata = mem[req_q.addr[IDX_W+1:2]];
         default: ;
      endcase
   end

   assign bus.hreadyout = rdy;
   assign bus.hresp     = {1'b0, err};
   assign bus.hrdata    = rdata;

   // Lane enables follow AHB little-endian byte placement on hwdata.
   always_comb begin
      case (req_q.size)
         2'd0:    be = 4'b0001 << req_q.addr[1:0];
         2'd1:    be = req_q.addr[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   // Memory is deliberately not reset; a write commits at the edge closing DATA.
   always_ff @(posedge hclk) begin
      if (!hreset && (state_q == S_DATA) && req_q.write) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) mem[req_q.addr[IDX_W+1:2]][8*b +: 8] <= bus.hwdata[8*b +: 8];
      end
   end
endmodule

// File: tb/tb_ahb_mem_slave_responder.sv
// Directed bench: one zero-wait responder and one three-wait responder on a shared bus.
module tb_ahb_mem_slave_responder;
   logic        hclk = 1'b0;
   logic        hreset;
   logic        hsel0, hsel3, hwrite, hready;
   logic [31:0] haddr, hwdata;
   logic [1:0]  htrans;
   logic [2:0]  hsize, hburst;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] bd [4];

   ahb_mem_slave_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();
   ahb_mem_slave_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b3 ();

   assign b0.hsel = hsel0;   assign b3.hsel = hsel3;
   assign b0.haddr = haddr;  assign b3.haddr = haddr;
   assign b0.htrans = htrans; assign b3.htrans = htrans;
   assign b0.hwrite = hwrite; assign b3.hwrite = hwrite;
   assign b0.hsize = hsize;  assign b3.hsize = hsize;
   assign b0.hburst = hburst; assign b3.hburst = hburst;
   assign b0.hwdata = hwdata; assign b3.hwdata = hwdata;
   assign hready = b0.hreadyout & b3.hreadyout;
   assign b0.hready = hready; assign b3.hready = hready;

   ahb_mem_slave_responder #(.WAIT_STATES(0)) dut0 (.hclk(hclk), .hreset(hreset), .bus(b0.slave));
   ahb_mem_slave_responder #(.WAIT_STATES(3)) dut3 (.hclk(hclk), .hreset(hreset), .bus(b3.slave));

   always #5 hclk = ~hclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic bus_idle();
      hsel0 = 1'b0; hsel3 = 1'b0; htrans = 2'b00; hwrite = 1'b0;
      hsize = 3'd2; hburst = 3'd0; haddr = '0;
   endtask

   // Zero-wait burst on dut0; bd[] holds write data or expected read data.
   task automatic burst0(input logic [31:0] a0, input logic w, input logic [2:0] sz,
                         input int n, input string tag);
      hsel0 = 1'b1; haddr = a0; htrans = 2'b10; hwrite = w; hsize = sz;
      hburst = (n == 4) ? 3'b011 : 3'b000;
      for (int i = 0; i < n; i++) begin
         @(negedge hclk);
         hwdata = w ? bd[i] : 32'h0;
         chk($sformatf("%s_rdy%0d", tag, i), 32'(b0.hreadyout), 32'd1);
         chk($sformatf("%s_resp%0d", tag, i), 32'(b0.hresp), 32'd0);
         chk($sformatf("%s_rd%0d", tag, i), b0.hrdata, w ? 32'h0 : bd[i]);
         if (i < n - 1) begin
            haddr = haddr + 32'd4; htrans = 2'b11;
         end else begin
            hsel0 = 1'b0; htrans = 2'b00;
         end
      end
      @(negedge hclk);
   endtask

   task automatic err0(input logic [31:0] a, input logic w, input logic [2:0] sz, input string tag);
      hsel0 = 1'b1; haddr = a; htrans = 2'b10; hwrite = w; hsize = sz;
      @(negedge hclk);
      hsel0 = 1'b0; htrans = 2'b00; hwdata = 32'hDEADBEEF;
      chk({tag, "_rdy1"}, 32'(b0.hreadyout), 32'd0);
      chk({tag, "_resp1"}, 32'(b0.hresp), 32'd1);
      @(negedge hclk);
      chk({tag, "_rdy2"}, 32'(b0.hreadyout), 32'd1);
      chk({tag, "_resp2"}, 32'(b0.hresp), 32'd1);
      chk({tag, "_rd2"}, b0.hrdata, 32'h0);
      @(negedge hclk);
      chk({tag, "_resp3"}, 32'(b0.hresp), 32'd0);
   endtask

   // Single word transfer on dut3; returns with dut3 in its DATA cycle, bus idled.
   task automatic single3(input logic [31:0] a, input logic w, input logic [31:0] d,
                          output int lows, output logic [31:0] rd, output logic [1:0] rsp);
      hsel3 = 1'b1; haddr = a; htrans = 2'b10; hwrite = w; hsize = 3'd2;
      lows = 0;
      @(negedge hclk);
      hsel3 = 1'b0; htrans = 2'b00; hwdata = d;
      for (int i = 0; i < 20; i++) begin
         if (b3.hreadyout) break;
         lows++;
         @(negedge hclk);
      end
      rd  = b3.hrdata;
      rsp = b3.hresp;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lows;
      logic [31:0] rd;
      logic [1:0]  rsp;
      hreset = 1'b1; hwdata = '0;
      bus_idle();
      repeat (3) @(negedge hclk);
      chk("rst_rdy", 32'(b0.hreadyout), 32'd1);
      chk("rst_resp", 32'(b0.hresp), 32'd0);
      chk("rst_rd", b0.hrdata, 32'h0);
      chk("rst_rdy3", 32'(b3.hreadyout), 32'd1);
      hreset = 1'b0;
      @(negedge hclk);

      // INCR4 write then read back
      bd[0] = 32'h11; bd[1] = 32'h12; bd[2] = 32'h13; bd[3] = 32'h52;
      burst0(32'h4000_0010, 1'b1, 3'd2, 4, "wr4");
      burst0(32'h4000_0010, 1'b0, 3'd2, 4, "rd4");

      // byte and halfword lanes over a cleared word
      bd[0] = 32'h0;         burst0(32'h4000_0020, 1'b1, 3'd2, 1, "clr");
      bd[0] = 32'h0000_00AA; burst0(32'h4000_0020, 1'b1, 3'd0, 1, "bw0");
      bd[0] = 32'hBB00_0000; burst0(32'h4000_0023, 1'b1, 3'd0, 1, "bw3");
      bd[0] = 32'hBB00_00AA; burst0(32'h4000_0020, 1'b0, 3'd2, 1, "brd");
      bd[0] = 32'h7766_0000; burst0(32'h4000_0022, 1'b1, 3'd1, 1, "hw2");
      bd[0] = 32'h7766_00AA; burst0(32'h4000_0020, 1'b0, 3'd2, 1, "hrd");

      // error responses, memory untouched
      err0(32'h4000_001E, 1'b0, 3'd2, "mis");
      err0(32'h4000_0100, 1'b0, 3'd2, "oob");
      err0(32'h4000_001E, 1'b1, 3'd2, "misw");
      err0(32'h4000_001C, 1'b1, 3'd3, "size");
      err0(32'h4000_0021, 1'b1, 3'd1, "mish");
      bd[0] = 32'h52; burst0(32'h4000_001C, 1'b0, 3'd2, 1, "keep");
      bd[0] = 32'hCAFE_F00D; burst0(32'h4000_00FC, 1'b1, 3'd2, 1, "lastw");
      burst0(32'h4000_00FC, 1'b0, 3'd2, 1, "lastr");

      // pipelined write -> read of the same word
      hsel0 = 1'b1; haddr = 32'h4000_0008; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
      @(negedge hclk);
      hwdata = 32'h1234; hwrite = 1'b0;
      chk("raw_rdy", 32'(b0.hreadyout), 32'd1);
      @(negedge hclk);
      chk("raw_rd", b0.hrdata, 32'h1234);
      hsel0 = 1'b0; htrans = 2'b00;
      @(negedge hclk);

      // unselected and BUSY transfers perform no access
      hsel0 = 1'b0; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h4000_0008;
      @(negedge hclk);
      hwdata = 32'hFFFF_FFFF; hsel0 = 1'b1; htrans = 2'b01;
      chk("nsel_rdy", 32'(b0.hreadyout), 32'd1);
      @(negedge hclk);
      chk("busy_rdy", 32'(b0.hreadyout), 32'd1);
      chk("busy_resp", 32'(b0.hresp), 32'd0);
      hsel0 = 1'b0; htrans = 2'b00;
      @(negedge hclk);
      bd[0] = 32'h1234; burst0(32'h4000_0008, 1'b0, 3'd2, 1, "nacc");

      // three wait states on dut3
      single3(32'h4000_0004, 1'b1, 32'h5A, lows, rd, rsp);
      chk("ws_wr_lows", 32'(lows), 32'd3);
      chk("ws_wr_resp", 32'(rsp), 32'd0);
      single3(32'h4000_0004, 1'b0, 32'h0, lows, rd, rsp);
      chk("ws_rd_lows", 32'(lows), 32'd3);
      chk("ws_rd_data", rd, 32'h5A);

      // reset during WAIT discards the pending write
      hsel3 = 1'b1; haddr = 32'h4000_0004; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
      @(negedge hclk);
      hsel3 = 1'b0; htrans = 2'b00; hwdata = 32'h77;
      chk("mid_wait", 32'(b3.hreadyout), 32'd0);
      hreset = 1'b1;
      #1;
      chk("mid_rst_rdy", 32'(b3.hreadyout), 32'd1);
      chk("mid_rst_resp", 32'(b3.hresp), 32'd0);
      chk("mid_rst_rd", b3.hrdata, 32'h0);
      @(negedge hclk);
      @(negedge hclk);
      hreset = 1'b0;
      @(negedge hclk);
      single3(32'h4000_0004, 1'b0, 32'h0, lows, rd, rsp);
      chk("mid_keep", rd, 32'h5A);
      @(negedge hclk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
